// File: rtl/uart_rx_if.sv
// Receive-side byte stream: one byte plus its error flags, moved on a valid/ready handshake.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       parity_err;
   logic       frame_err;

   modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
   modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8-bit UART receiver: start, 8 data LSB first, parity, 1 or 2 stops; mid-bit sampling,
// parity/framing checks, single-entry output register with sticky overrun.
module uart_rx #(
   parameter int BAUD_DIVISOR = 868,
   parameter int HALF_DIV     = BAUD_DIVISOR / 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Rx_en,
   input  logic        Two_stop,
   input  logic        Odd_parity,
   input  logic        Rx_in,
   uart_rx_if.master   rx,
   output logic        overrun,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

   localparam logic [13:0] TICK_VAL = 14'(BAUD_DIVISOR - 1);
   localparam logic [13:0] HALF_VAL = 14'(HALF_DIV - 1);

   state_t      state, state_n;
   logic [1:0]  sync;
   logic        rx_s;
   logic [13:0] baud_count;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        perr, ferr;
   logic        two_stop_r, odd_r;
   logic        tick, complete, ferr_fin, accept;

   assign rx_s   = sync[1];
   assign tick   = (baud_count == TICK_VAL);
   assign accept = rx.rx_valid & rx.rx_ready;
   assign busy   = (state != IDLE);

   always_comb begin
      state_n  = state;
      complete = 1'b0;
      ferr_fin = ferr;
      case (state)
         IDLE:      if (Rx_en && !rx_s) state_n = START;
         START:     if (baud_count == HALF_VAL) state_n = rx_s ? IDLE : DATA;
         DATA:      if (tick && bit_idx == 3'd7) state_n = PARITY;
         PARITY:    if (tick) state_n = STOP1;
         STOP1: if (tick) begin
            ferr_fin = ~rx_s;
            if (two_stop_r) state_n = STOP2;
            else            complete = 1'b1;
         end
         STOP2: if (tick) begin
            ferr_fin = ferr | ~rx_s;
            complete = 1'b1;
         end
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
      // a line still low after a framing error is a break: wait for idle before re-arming
      if (complete) state_n = (ferr_fin && !rx_s) ? WAIT_HIGH : IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sync          <= 2'b11;
         baud_count    <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         perr          <= 1'b0;
         ferr          <= 1'b0;
         two_stop_r    <= 1'b0;
         odd_r         <= 1'b0;
         rx.rx_data    <= 8'h00;
         rx.rx_valid   <= 1'b0;
         rx.parity_err <= 1'b0;
         rx.frame_err  <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         sync  <= {sync[0], Rx_in};
         state <= state_n;

         if (state_n != state || tick) baud_count <= '0;
         else                          baud_count <= baud_count + 14'd1;

         if (state == IDLE && state_n == START) begin
            two_stop_r <= Two_stop;
            odd_r      <= Odd_parity;
         end
         if (state == START && state_n == DATA) bit_idx <= '0;

         if (state == DATA && tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == PARITY && tick) perr <= ((^shift) ^ rx_s) != odd_r;
         if ((state == STOP1 || state == STOP2) && tick) ferr <= ferr_fin;

         if (complete && (!rx.rx_valid || accept)) begin
            rx.rx_data    <= shift;
            rx.parity_err <= perr;
            rx.frame_err  <= ferr_fin;
            rx.rx_valid   <= 1'b1;
         end else if (accept) begin
            rx.rx_valid   <= 1'b0;
         end

         // set has priority over the handshake clear
         if (complete && rx.rx_valid && !accept) overrun <= 1'b1;
         else if (accept)                        overrun <= 1'b0;
      end
   end
endmodule
